// File: rtl/token_ring_rotator_if.sv
// Request/ring bundle for token_ring_rotator: control, load and rotate inputs
// driven by the master, registered ring contents and run status from the slave.
interface token_ring_rotator_if #(
    parameter int N       = 4,
    parameter int SHAMT_W = 2,
    parameter int CNT_W   = 8
);
    logic               load;
    logic [N-1:0]       datain;
    logic               en;
    logic               start;
    logic               dir;
    logic [SHAMT_W-1:0] shamt;
    logic [CNT_W-1:0]   nrot;
    logic [N-1:0]       data;
    logic               busy;
    logic               done;

    modport master (
        output load, datain, en, start, dir, shamt, nrot,
        input  data, busy, done
    );

    modport slave (
        input  load, datain, en, start, dir, shamt, nrot,
        output data, busy, done
    );
endinterface

// File: rtl/token_ring_rotator.sv
// N-bit rotating ring with parallel load, single-step rotate and a counted
// multi-step run (IDLE -> RUN -> DONE) that freezes its settings at start.
module token_ring_rotator #(
    parameter int N       = 4,
    parameter int SHAMT_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    token_ring_rotator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       data_q,  data_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SHAMT_W-1:0] k_q,     k_d;
    logic               dir_q,   dir_d;

    function automatic logic [SHAMT_W-1:0] step_of(input logic [SHAMT_W-1:0] s);
        return SHAMT_W'(32'(s) % 32'(N));
    endfunction

    // Doubling the ring turns a rotate by k < N into a plain shift.
    function automatic logic [N-1:0] rotate(input logic [N-1:0] d,
                                            input logic [SHAMT_W-1:0] k,
                                            input logic left);
        logic [2*N-1:0] dd;
        dd = {d, d};
        if (left) begin
            dd = dd << k;
            return dd[2*N-1:N];
        end
        dd = dd >> k;
        return dd[N-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    data_d = bus.datain;
                end else if (bus.start) begin
                    k_d     = step_of(bus.shamt);
                    dir_d   = bus.dir;
                    cnt_d   = bus.nrot;
                    state_d = (bus.nrot == '0) ? DONE : RUN;
                end else if (bus.en) begin
                    data_d = rotate(data_q, step_of(bus.shamt), bus.dir);
                end
            end
            RUN: begin
                data_d = rotate(data_q, k_q, dir_q);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.data = data_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule
